// File: rtl/mvm_noc_loader.sv
// Streams raw words into NoC packets (weight or vector load) through a single output register.
// Optional feature: define MVM_LOADER_DEST_GAP_EN for a one-cycle input gap between destinations.
module mvm_noc_loader #(
    parameter int DATAW          = 512,
    parameter int DESTW          = 12,
    parameter int WORDS_PER_DEST = 64,
    parameter int USERW          = 75,
    parameter int CNTW           = 12
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CFG_START,
    input  logic             CFG_MODE,
    input  logic [DESTW-1:0] CFG_BASE_DEST,
    input  logic [CNTW-1:0]  CFG_NUM_DEST,
    input  logic [8:0]       CFG_RF_ADDR,
    output logic             BUSY,
    output logic             DONE,
    input  logic             S_TVALID,
    output logic             S_TREADY,
    input  logic [DATAW-1:0] S_TDATA,
    output logic             M_TVALID,
    input  logic             M_TREADY,
    output logic [DATAW-1:0] M_TDATA,
    output logic [DESTW-1:0] M_TDEST,
    output logic [USERW-1:0] M_TUSER,
    output logic             M_TLAST
);

    localparam int LINEW = (WORDS_PER_DEST > 1) ? $clog2(WORDS_PER_DEST) : 1;

    generate
        if (USERW != 11 + WORDS_PER_DEST) begin : g_userw_check
            $error("mvm_noc_loader: USERW must equal 11 + WORDS_PER_DEST");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, FIN} state_t;

    state_t             state;
    logic               mode_p0;
    logic [8:0]         rf_addr_p0;
    logic [CNTW-1:0]    num_dest_p0;
    logic [CNTW-1:0]    dest_cnt_p0;
    logic [DESTW-1:0]   dest_p0;
    logic [LINEW-1:0]   line_p0;
    logic               gap_p0;

    logic               vld_p1;
    logic [DATAW-1:0]   data_p1;
    logic [DESTW-1:0]   dest_p1;
    logic [USERW-1:0]   user_p1;
    logic               last_p1;
    logic               busy_p1;
    logic               done_p1;

    logic               out_free;
    logic               accept;
    logic               last_line;
    logic               last_dest;

    function automatic logic [USERW-1:0] make_user(input logic mode, input logic [8:0] rf,
                                                   input logic [LINEW-1:0] line);
        logic [WORDS_PER_DEST-1:0] onehot;
        onehot       = '0;
        onehot[line] = 1'b1;
        if (mode)
            make_user = USERW'({{WORDS_PER_DEST{1'b0}}, 2'b10, 9'd0});
        else
            make_user = USERW'({onehot, 2'b11, rf});
    endfunction

    // The output register may take a new word whenever it is empty or draining this cycle.
    assign out_free  = !vld_p1 || M_TREADY;
    assign S_TREADY  = (state == RUN) && out_free && !gap_p0;
    assign accept    = S_TVALID && S_TREADY;
    assign last_line = mode_p0 || (line_p0 == LINEW'(WORDS_PER_DEST - 1));
    assign last_dest = (dest_cnt_p0 == num_dest_p0 - 1'b1);

    assign M_TVALID = vld_p1;
    assign M_TDATA  = data_p1;
    assign M_TDEST  = dest_p1;
    assign M_TUSER  = user_p1;
    assign M_TLAST  = last_p1;
    assign BUSY     = busy_p1;
    assign DONE     = done_p1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= IDLE;
            mode_p0     <= 1'b0;
            rf_addr_p0  <= '0;
            num_dest_p0 <= '0;
            dest_cnt_p0 <= '0;
            dest_p0     <= '0;
            line_p0     <= '0;
            gap_p0      <= 1'b0;
            vld_p1      <= 1'b0;
            data_p1     <= '0;
            dest_p1     <= '0;
            user_p1     <= '0;
            last_p1     <= 1'b0;
            busy_p1     <= 1'b0;
            done_p1     <= 1'b0;
        end else begin
`ifdef MVM_LOADER_DEST_GAP_EN
            gap_p0 <= accept && last_line && !last_dest;
`else
            gap_p0 <= 1'b0;
`endif
            // stage p0 -> p1: single output register, reloads in the same cycle it drains
            if (accept) begin
                vld_p1  <= 1'b1;
                data_p1 <= S_TDATA;
                dest_p1 <= dest_p0;
                user_p1 <= make_user(mode_p0, rf_addr_p0, line_p0);
                last_p1 <= 1'b1;
            end else if (M_TREADY) begin
                vld_p1 <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (CFG_START) begin
                        mode_p0     <= CFG_MODE;
                        rf_addr_p0  <= CFG_RF_ADDR;
                        num_dest_p0 <= CFG_NUM_DEST;
                        dest_p0     <= CFG_BASE_DEST;
                        dest_cnt_p0 <= '0;
                        line_p0     <= '0;
                        if (CFG_NUM_DEST != '0) begin
                            state   <= RUN;
                            busy_p1 <= 1'b1;
                        end else begin
                            state   <= FIN;
                            done_p1 <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_line) begin
                            line_p0     <= '0;
                            dest_cnt_p0 <= dest_cnt_p0 + 1'b1;
                            dest_p0     <= dest_p0 + 1'b1;
                            if (last_dest)
                                state <= FLUSH;
                        end else begin
                            line_p0 <= line_p0 + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    if (vld_p1 && M_TREADY) begin
                        state   <= FIN;
                        busy_p1 <= 1'b0;
                        done_p1 <= 1'b1;
                    end
                end
                FIN: begin
                    done_p1 <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mvm_noc_loader.sv
// Directed self-checking bench for mvm_noc_loader; expectations depend on MVM_LOADER_DEST_GAP_EN.
module tb_mvm_noc_loader;

    localparam int DATAW = 512;
    localparam int DESTW = 12;
    localparam int WPD   = 64;
    localparam int USERW = 75;
    localparam int CNTW  = 12;
`ifdef MVM_LOADER_DEST_GAP_EN
    localparam int EXP_GAP = 1;
`else
    localparam int EXP_GAP = 0;
`endif

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             CFG_START = 1'b0;
    logic             CFG_MODE = 1'b0;
    logic [DESTW-1:0] CFG_BASE_DEST = '0;
    logic [CNTW-1:0]  CFG_NUM_DEST = '0;
    logic [8:0]       CFG_RF_ADDR = '0;
    logic             BUSY;
    logic             DONE;
    logic             S_TVALID = 1'b0;
    logic             S_TREADY;
    logic [DATAW-1:0] S_TDATA = '0;
    logic             M_TVALID;
    logic             M_TREADY = 1'b1;
    logic [DATAW-1:0] M_TDATA;
    logic [DESTW-1:0] M_TDEST;
    logic [USERW-1:0] M_TUSER;
    logic             M_TLAST;

    mvm_noc_loader #(
        .DATAW(DATAW), .DESTW(DESTW), .WORDS_PER_DEST(WPD), .USERW(USERW), .CNTW(CNTW)
    ) dut (
        .CLK(CLK), .RST(RST), .CFG_START(CFG_START), .CFG_MODE(CFG_MODE),
        .CFG_BASE_DEST(CFG_BASE_DEST), .CFG_NUM_DEST(CFG_NUM_DEST), .CFG_RF_ADDR(CFG_RF_ADDR),
        .BUSY(BUSY), .DONE(DONE), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY), .S_TDATA(S_TDATA),
        .M_TVALID(M_TVALID), .M_TREADY(M_TREADY), .M_TDATA(M_TDATA), .M_TDEST(M_TDEST),
        .M_TUSER(M_TUSER), .M_TLAST(M_TLAST)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    logic [DATAW-1:0] src_words[$];
    int               src_idx = 0;
    bit               src_en = 1'b0;
    int               rdy_mode = 0;
    int               cyc_cnt = 0;
    bit [3:0]         pat = 4'b1001;

    logic [DATAW-1:0] b_data[$];
    logic [DESTW-1:0] b_dest[$];
    logic [USERW-1:0] b_user[$];
    logic             b_last[$];
    int               done_cnt = 0;
    int               stall_viol = 0;
    int               rdy_viol = 0;
    int               stall_cnt = 0;
    int               gap_lows = 0;
    bit               hold_v = 1'b0;
    logic [DATAW-1:0] h_data;
    logic [DESTW-1:0] h_dest;
    logic [USERW-1:0] h_user;

    // Observe on the falling edge: whatever handshakes are visible now complete at the next rising edge.
    always @(negedge CLK) begin
        if (M_TVALID && M_TREADY) begin
            b_data.push_back(M_TDATA);
            b_dest.push_back(M_TDEST);
            b_user.push_back(M_TUSER);
            b_last.push_back(M_TLAST);
        end
        if (hold_v && (!M_TVALID || M_TDATA !== h_data || M_TDEST !== h_dest ||
                       M_TUSER !== h_user || M_TLAST !== 1'b1))
            stall_viol++;
        if (M_TVALID && !M_TREADY) begin
            stall_cnt++;
            if (S_TREADY) rdy_viol++;
        end
        hold_v = M_TVALID && !M_TREADY;
        h_data = M_TDATA;
        h_dest = M_TDEST;
        h_user = M_TUSER;
        if (rdy_mode == 0 && src_idx == WPD && S_TVALID && !S_TREADY && BUSY)
            gap_lows++;
        if (S_TVALID && S_TREADY) src_idx++;
        if (DONE) done_cnt++;
    end

    task automatic step();
        @(posedge CLK);
        #1;
        cyc_cnt++;
        M_TREADY = (rdy_mode == 0) ? 1'b1 : pat[cyc_cnt % 4];
        S_TVALID = src_en && (src_idx < src_words.size());
        S_TDATA  = S_TVALID ? src_words[src_idx] : '0;
    endtask

    task automatic prep(input int n);
        b_data.delete(); b_dest.delete(); b_user.delete(); b_last.delete();
        src_words.delete();
        for (int k = 0; k < n; k++)
            src_words.push_back({32'hC0DE0000 + 32'(k), 448'd0, 32'(k * 7 + 3)});
        src_idx = 0; done_cnt = 0; stall_viol = 0; rdy_viol = 0; stall_cnt = 0;
        gap_lows = 0; hold_v = 1'b0; src_en = 1'b1;
    endtask

    task automatic start(input logic mode, input logic [DESTW-1:0] base,
                         input logic [CNTW-1:0] num, input logic [8:0] rf);
        step();
        CFG_MODE = mode; CFG_BASE_DEST = base; CFG_NUM_DEST = num; CFG_RF_ADDR = rf;
        CFG_START = 1'b1;
        step();
        CFG_START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL %s_done_timeout: no DONE within %0d cycles", tag, budget);
        end
        repeat (4) step();
    endtask

    task automatic check_weight(input string tag, input int ndest, input logic [DESTW-1:0] base,
                                input logic [8:0] rf);
        int               n, e_dest, e_user, e_data, e_last;
        logic [DESTW-1:0] exp_dest;
        logic [USERW-1:0] exp_user;
        n = b_data.size();
        e_dest = 0; e_user = 0; e_data = 0; e_last = 0;
        tests++;
        if (n !== ndest * WPD) begin
            fails++;
            $display("FAIL %s_beat_count: got %0d, expected %0d", tag, n, ndest * WPD);
        end
        for (int k = 0; k < n && k < ndest * WPD; k++) begin
            exp_dest = base + DESTW'(k / WPD);
            exp_user = '0;
            exp_user[8:0] = rf;
            exp_user[10:9] = 2'b11;
            exp_user[11 + (k % WPD)] = 1'b1;
            if (b_dest[k] !== exp_dest) e_dest++;
            if (b_user[k] !== exp_user) e_user++;
            if (b_data[k] !== src_words[k]) e_data++;
            if (b_last[k] !== 1'b1) e_last++;
        end
        tests++;
        if (e_dest != 0) begin fails++; $display("FAIL %s_tdest: %0d beats wrong, expected 0", tag, e_dest); end
        tests++;
        if (e_user != 0) begin fails++; $display("FAIL %s_tuser: %0d beats wrong, expected 0", tag, e_user); end
        tests++;
        if (e_data != 0) begin fails++; $display("FAIL %s_tdata: %0d beats wrong, expected 0", tag, e_data); end
        tests++;
        if (e_last != 0) begin fails++; $display("FAIL %s_tlast: %0d beats wrong, expected 0", tag, e_last); end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL %s_done_count: got %0d, expected 1", tag, done_cnt); end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #2;
        tests++;
        if (M_TVALID !== 1'b0 || M_TDATA !== '0 || M_TDEST !== '0 || M_TUSER !== '0 ||
            M_TLAST !== 1'b0 || S_TREADY !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: tvalid=%b tdest=%h tuser=%h tlast=%b sready=%b busy=%b done=%b, expected all 0",
                     M_TVALID, M_TDEST, M_TUSER, M_TLAST, S_TREADY, BUSY, DONE);
        end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        prep(4);
        repeat (3) step();
        tests++;
        if (S_TREADY !== 1'b0 || BUSY !== 1'b0 || src_idx !== 0) begin
            fails++;
            $display("FAIL idle_no_accept: sready=%b busy=%b accepted=%0d, expected 0 0 0",
                     S_TREADY, BUSY, src_idx);
        end
        src_en = 1'b0;
    endtask

    task automatic test_weight_load();
        prep(2 * WPD);
        rdy_mode = 0;
        start(1'b0, 12'h001, 12'd2, 9'h001);
        tests++;
        if (BUSY !== 1'b1) begin fails++; $display("FAIL weight_busy: got %b, expected 1", BUSY); end
        wait_done("weight", 400);
        check_weight("weight", 2, 12'h001, 9'h001);
        tests++;
        if (gap_lows !== EXP_GAP) begin
            fails++;
            $display("FAIL weight_dest_gap: got %0d stall cycles, expected %0d", gap_lows, EXP_GAP);
        end
        tests++;
        if (BUSY !== 1'b0) begin fails++; $display("FAIL weight_busy_end: got %b, expected 0", BUSY); end
    endtask

    task automatic test_vector_load();
        prep(2);
        start(1'b1, 12'h001, 12'd2, 9'h1FF);
        wait_done("vector", 50);
        tests++;
        if (b_data.size() !== 2) begin
            fails++;
            $display("FAIL vector_beat_count: got %0d, expected 2", b_data.size());
        end else begin
            tests++;
            if (b_data[0] !== src_words[0] || b_data[1] !== src_words[1]) begin
                fails++; $display("FAIL vector_tdata: beat words out of order or corrupted, expected A then B");
            end
            tests++;
            if (b_dest[0] !== 12'h001 || b_dest[1] !== 12'h002) begin
                fails++; $display("FAIL vector_tdest: got %h %h, expected 001 002", b_dest[0], b_dest[1]);
            end
            tests++;
            if (b_user[0] !== 75'h400 || b_user[1] !== 75'h400) begin
                fails++; $display("FAIL vector_tuser: got %h %h, expected 400 400", b_user[0], b_user[1]);
            end
        end
        tests++;
        if (done_cnt !== 1) begin fails++; $display("FAIL vector_done_count: got %0d, expected 1", done_cnt); end
    endtask

    task automatic test_backpressure();
        prep(WPD);
        rdy_mode = 1;
        start(1'b0, 12'h020, 12'd1, 9'h0A5);
        wait_done("bp", 600);
        rdy_mode = 0;
        check_weight("bp", 1, 12'h020, 9'h0A5);
        tests++;
        if (stall_viol !== 0) begin fails++; $display("FAIL bp_stable: %0d unstable stall cycles, expected 0", stall_viol); end
        tests++;
        if (rdy_viol !== 0 || stall_cnt == 0) begin
            fails++;
            $display("FAIL bp_sready: sready-high-while-stalled=%0d stalls=%0d, expected 0 and >0", rdy_viol, stall_cnt);
        end
    endtask

    task automatic test_zero_dest();
        prep(0);
        src_en = 1'b0;
        step();
        CFG_MODE = 1'b0; CFG_BASE_DEST = 12'h123; CFG_NUM_DEST = '0; CFG_START = 1'b1;
        step();
        CFG_START = 1'b0;
        tests++;
        if (DONE !== 1'b1 || BUSY !== 1'b0) begin
            fails++; $display("FAIL zero_done: done=%b busy=%b, expected 1 0", DONE, BUSY);
        end
        step();
        tests++;
        if (DONE !== 1'b0) begin fails++; $display("FAIL zero_done_pulse: got %b, expected 0", DONE); end
        repeat (3) step();
        tests++;
        if (b_data.size() !== 0 || done_cnt !== 1) begin
            fails++; $display("FAIL zero_beats: beats=%0d dones=%0d, expected 0 1", b_data.size(), done_cnt);
        end
    endtask

    task automatic test_wrap();
        prep(2);
        start(1'b1, 12'hFFF, 12'd2, 9'h000);
        wait_done("wrap", 50);
        tests++;
        if (b_dest.size() !== 2) begin
            fails++; $display("FAIL wrap_count: got %0d, expected 2", b_dest.size());
        end else begin
            tests++;
            if (b_dest[0] !== 12'hFFF || b_dest[1] !== 12'h000) begin
                fails++; $display("FAIL wrap_tdest: got %h %h, expected fff 000", b_dest[0], b_dest[1]);
            end
        end
    endtask

    task automatic test_start_during_run();
        int n;
        prep(WPD);
        start(1'b0, 12'h010, 12'd1, 9'h003);
        n = 0;
        while (b_data.size() < 5 && n < 100) begin step(); n++; end
        CFG_MODE = 1'b1; CFG_BASE_DEST = 12'h055; CFG_NUM_DEST = 12'd3; CFG_RF_ADDR = 9'h000;
        CFG_START = 1'b1;
        step();
        CFG_START = 1'b0;
        tests++;
        if (BUSY !== 1'b1) begin fails++; $display("FAIL runstart_busy: got %b, expected 1", BUSY); end
        wait_done("runstart", 300);
        check_weight("runstart", 1, 12'h010, 9'h003);
    endtask

    task automatic test_async_reset();
        int n;
        prep(2 * WPD);
        start(1'b0, 12'h001, 12'd2, 9'h001);
        n = 0;
        while (b_data.size() < 10 && n < 100) begin step(); n++; end
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if (M_TVALID !== 1'b0 || M_TDATA !== '0 || M_TDEST !== '0 || M_TUSER !== '0 ||
            M_TLAST !== 1'b0 || S_TREADY !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0) begin
            fails++;
            $display("FAIL areset_outputs: tvalid=%b tdest=%h tuser=%h tlast=%b sready=%b busy=%b done=%b, expected all 0",
                     M_TVALID, M_TDEST, M_TUSER, M_TLAST, S_TREADY, BUSY, DONE);
        end
        src_en = 1'b0;
        repeat (2) step();
        RST = 1'b0;
        repeat (5) step();
        tests++;
        if (done_cnt !== 0 || BUSY !== 1'b0) begin
            fails++; $display("FAIL areset_no_done: dones=%0d busy=%b, expected 0 0", done_cnt, BUSY);
        end
        prep(2 * WPD);
        start(1'b0, 12'h001, 12'd2, 9'h001);
        wait_done("rerun", 400);
        check_weight("rerun", 2, 12'h001, 9'h001);
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_vector_load();
        test_backpressure();
        test_zero_dest();
        test_wrap();
        test_start_during_run();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded 1 ms, expected completion");
        $fatal(1, "timeout");
    end

endmodule
